mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory between the IF-stage instruction fetch port and the MEM-stage load/store port of the pipelined RISC-V core. It arbitrates, latches and issues one access at a time, waits out the memory read latency, and returns data with a one-cycle acknowledge pulse. An unacknowledged request is the stall condition the pipeline uses to freeze PC, IF/ID and downstream stages.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_arb_lat_timer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner tags and
// the largest supported memory read latency.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int ARB_LAT_MAX = 7;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the arbiter: fetch port (if_*), load/store port (d_*)
// and the single-port memory side (mem_*). slave = arbiter, master = env.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_ack;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_ack;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic [DATA_W/8-1:0]   mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_lat_timer.sv
// Read-latency down-counter: load sets MEM_LAT-1, dec counts toward 0.
// Ports: clk, rst (async, active-high), load, dec, zero (count == 0).
module mem_arb_lat_timer #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync memory between fetch and load/store ports.
// Ports: clk, rst (async, active-high), bus (slave modport), busy.
// Optional macro MEM_ARB_STARVE_GUARD_EN: forces a fetch grant after
// STARVE_MAX consecutive data grants made while a fetch was pending.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int STRB_W = DATA_W / 8;

    if (MEM_LAT < 1 || MEM_LAT > ARB_LAT_MAX || STARVE_MAX < 1) begin : g_cfg_err
        $error("mem_port_arbiter: MEM_LAT or STARVE_MAX out of range");
    end

    arb_state_t         state;
    arb_state_t         state_nx;
    owner_t             owner;
    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_wdata;
    logic [STRB_W-1:0]  lat_wstrb;

    logic               if_ack_q;
    logic               d_ack_q;
    logic [DATA_W-1:0]  if_rdata_q;
    logic [DATA_W-1:0]  d_rdata_q;

    logic               decide;
    logic               starved;
    logic               pick_d;
    logic               pick_i;
    logic               grant;
    logic               fin;
    logic               issue;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;

    // DONE also arbitrates so the next access starts in the ack cycle.
    assign decide = (state == IDLE) || (state == DONE);
    assign pick_d = bus.d_req && !starved;
    assign pick_i = bus.if_req && !pick_d;
    assign grant  = decide && (pick_d || pick_i);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SV_W = $clog2(STARVE_MAX + 1);

    logic [SV_W-1:0] starve_cnt;

    assign starved = bus.if_req && (starve_cnt == SV_W'(STARVE_MAX));

    // Saturates at STARVE_MAX: at that value a pending fetch wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (pick_d && bus.if_req) begin
                starve_cnt <= starve_cnt + SV_W'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`else
    assign starved = 1'b0;
`endif

    mem_arb_lat_timer #(
        .MEM_LAT (MEM_LAT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .zero (tmr_zero)
    );

    // Reads always pass through WAIT: the WAIT cycle seen with the
    // counter at 0 is the cycle mem_rdata is valid, so it is captured
    // on that edge and ack/rdata appear together in DONE.
    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) state_nx = ISSUE;
            end
            ISSUE: begin
                if (lat_we) begin
                    fin      = 1'b1;
                    state_nx = DONE;
                end else begin
                    tmr_load = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (tmr_zero) begin
                    fin      = 1'b1;
                    state_nx = DONE;
                end else begin
                    tmr_dec  = 1'b1;
                end
            end
            DONE: begin
                state_nx = grant ? ISSUE : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_wstrb  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state    <= state_nx;
            if_ack_q <= fin && (owner == OWN_I);
            d_ack_q  <= fin && (owner == OWN_D);
            if (fin && !lat_we) begin
                if (owner == OWN_I) begin
                    if_rdata_q <= bus.mem_rdata;
                end else begin
                    d_rdata_q  <= bus.mem_rdata;
                end
            end
            if (grant) begin
                owner     <= pick_d ? OWN_D : OWN_I;
                lat_addr  <= pick_d ? bus.d_addr : bus.if_addr;
                lat_we    <= pick_d && bus.d_we;
                lat_wstrb <= pick_d ? bus.d_wstrb : '0;
                lat_wdata <= pick_d ? bus.d_wdata : '0;
            end
        end
    end

    assign issue         = (state == ISSUE);
    assign busy          = (state != IDLE);
    assign bus.mem_en    = issue;
    assign bus.mem_we    = (issue && lat_we) ? lat_wstrb : '0;
    assign bus.mem_addr  = issue ? lat_addr : '0;
    assign bus.mem_wdata = issue ? lat_wdata : '0;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2) with
// scoreboards for memory strobes and acknowledges.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        bit          st;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          cyc;
    } ack_exp_t;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   c0;
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;
    logic [31:0] p1, p2;

    mem_exp_t memq[$];
    ack_exp_t ackq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Two-cycle read pipe: data valid MEM_LAT=2 cycles after mem_en,
    // poison value in every other cycle.
    always @(posedge clk) begin
        p1 <= bus.mem_en ? rd(bus.mem_addr) : 32'hBAD0BAD0;
        p2 <= p1;
    end
    assign bus.mem_rdata = p2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic [31:0] a, input logic [3:0] we,
                            input logic [31:0] wd, input bit st,
                            input int c);
        mem_exp_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.st = st; e.cyc = c;
        memq.push_back(e);
    endtask

    task automatic push_ack(input bit is_d, input logic [31:0] d,
                            input int c);
        ack_exp_t e;
        e.is_d = is_d; e.data = d; e.cyc = c;
        ackq.push_back(e);
    endtask

    task automatic wait_ack(input bit is_d);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (is_d ? bus.d_ack : bus.if_ack) begin
                seen = 1'b1;
                if (is_d) bus.d_req = 1'b0;
                else      bus.if_req = 1'b0;
            end
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL ack_timeout: port_d=%0d got seen=%0d expected 1",
                   is_d, seen);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_en) begin
                if (memq.size() == 0) begin
                    chk("mem_en_unexpected", 32'(bus.mem_en), 32'h0);
                end else begin
                    mem_exp_t m;
                    m = memq.pop_front();
                    chk("mem_addr", bus.mem_addr, m.addr);
                    chk("mem_we", 32'(bus.mem_we), 32'(m.we));
                    chk("mem_cyc", cyc, m.cyc);
                    if (m.st) chk("mem_wdata", bus.mem_wdata, m.wdata);
                end
            end
            if (bus.if_ack || bus.d_ack) begin
                chk("ack_onehot", 32'(bus.if_ack & bus.d_ack), 32'h0);
                if (ackq.size() == 0) begin
                    chk("ack_unexpected", 32'({bus.if_ack, bus.d_ack}), 32'h0);
                end else begin
                    ack_exp_t a;
                    a = ackq.pop_front();
                    chk("ack_port_d", 32'(bus.d_ack), 32'(a.is_d));
                    chk("ack_cyc", cyc, a.cyc);
                    if (a.is_d) begin
                        chk("d_rdata", bus.d_rdata, a.data);
                        chk("if_rdata_hold", bus.if_rdata, last_i);
                        last_d = a.data;
                    end else begin
                        chk("if_rdata", bus.if_rdata, a.data);
                        chk("d_rdata_hold", bus.d_rdata, last_d);
                        last_i = a.data;
                    end
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'h0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'h0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, "_acks"}, 32'({bus.if_ack, bus.d_ack}), 32'h0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 32'h0);
        chk({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_wstrb = '0;
        rst = 1'b1;
        repeat (2) tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Fetch with MEM_LAT=2.
        tick(); c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        push_mem(32'h100, 4'h0, 32'h0, 1'b0, c0 + 1);
        push_ack(1'b0, 32'h00500093, c0 + 4);
        chk("t1_busy_c0", 32'(busy), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t1_busy", 32'(busy), 32'h1);
        end
        wait_ack(1'b0);
        tick();
        chk("t1_idle", 32'(busy), 32'h0);
        chk("t1_if_rdata_held", bus.if_rdata, 32'h00500093);

        // Simultaneous load and fetch: data first.
        tick(); c0 = cyc;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000;
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        push_mem(32'h2000, 4'h0, 32'h0, 1'b0, c0 + 1);
        push_mem(32'h104, 4'h0, 32'h0, 1'b0, c0 + 5);
        push_ack(1'b1, rd(32'h2000), c0 + 4);
        push_ack(1'b0, rd(32'h104), c0 + 8);
        wait_ack(1'b1);
        wait_ack(1'b0);

        // Partial store, then a store with no byte enables.
        tick(); c0 = cyc;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2004;
        bus.d_wdata = 32'hDEADBEEF; bus.d_wstrb = 4'b0011;
        push_mem(32'h2004, 4'b0011, 32'hDEADBEEF, 1'b1, c0 + 1);
        push_ack(1'b1, rd(32'h2000), c0 + 2);
        wait_ack(1'b1);
        chk("st_mem_we_after", 32'(bus.mem_we), 32'h0);
        tick(); c0 = cyc;
        bus.d_req = 1'b1; bus.d_addr = 32'h2008;
        bus.d_wdata = 32'h12345678; bus.d_wstrb = 4'b0000;
        push_mem(32'h2008, 4'b0000, 32'h12345678, 1'b1, c0 + 1);
        push_ack(1'b1, rd(32'h2000), c0 + 2);
        wait_ack(1'b1);
        bus.d_we = 1'b0; bus.d_wstrb = '0;
        tick();

        // Both requests held high for six back-to-back grants.
        tick(); c0 = cyc;
        bus.d_req = 1'b1; bus.d_addr = 32'h3000;
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        for (int k = 0; k < 6; k++) begin
            bit dk;
            dk = GUARD ? ((k % 3) != 2) : 1'b1;
            push_mem(dk ? 32'h3000 : 32'h400, 4'h0, 32'h0, 1'b0,
                     c0 + 1 + 4 * k);
            push_ack(dk, rd(dk ? 32'h3000 : 32'h400), c0 + 4 + 4 * k);
        end
        repeat (24) tick();
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        tick();
        chk("starve_idle", 32'(busy), 32'h0);

        // Reset in the middle of a fetch.
        tick(); c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h108;
        push_mem(32'h108, 4'h0, 32'h0, 1'b0, c0 + 1);
        repeat (2) tick();
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        bus.if_req = 1'b0;
        last_i = '0; last_d = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("post_rst_idle", 32'(busy), 32'h0);
        c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h10C;
        push_mem(32'h10C, 4'h0, 32'h0, 1'b0, c0 + 1);
        push_ack(1'b0, rd(32'h10C), c0 + 4);
        wait_ack(1'b0);
        repeat (3) tick();

        chk("memq_drained", 32'(memq.size()), 32'h0);
        chk("ackq_drained", 32'(ackq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
